// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core's memory-side responders.
// Word geometry and the response record travelling down the latency pipeline.
package riscv_mem_pkg;

    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = WORD_W / 8;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [WORD_W-1:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/riscv_data_mem_responder_if.sv
// Data-side request/response bus between riscv_core (master) and the memory responder (slave).
interface riscv_data_mem_responder_if;
    import riscv_mem_pkg::*;

    logic                  data_req_i;
    logic                  data_gnt_o;
    logic [WORD_W-1:0]     data_addr_i;
    logic                  data_we_i;
    logic [WORD_BYTES-1:0] data_be_i;
    logic [WORD_W-1:0]     data_wdata_i;
    logic                  data_rvalid_o;
    logic [WORD_W-1:0]     data_rdata_o;
    logic                  data_err_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/riscv_mem_resp_pipe.sv
// Fixed-length shift register delaying responses by STAGES cycles.
// Reset clears every stage so in-flight transactions never emerge.
module riscv_mem_resp_pipe
    import riscv_mem_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  mem_resp_t head,
    output mem_resp_t tail
);

    mem_resp_t resp_p [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                resp_p[i] <= '0;
            end
        end else begin
            resp_p[0] <= head;
            for (int i = 1; i < STAGES; i++) begin
                resp_p[i] <= resp_p[i-1];
            end
        end
    end

    assign tail = resp_p[STAGES-1];

endmodule

// File: rtl/riscv_data_mem_responder.sv
// Memory-side responder for the core's data port: stalled grant, byte-enable
// word memory with a backdoor preload port, and in-order fixed-latency responses.
module riscv_data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 14,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          GNT_STALL       = 0,
    parameter int          RESP_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    riscv_data_mem_responder_if.slave   bus,
    input  logic                        bd_we_i,
    input  logic [ADDR_WIDTH-1:0]       bd_addr_i,
    input  logic [WORD_W-1:0]           bd_wdata_i
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] STALL_LIM = 4'(GNT_STALL);
    localparam logic [3:0] OUT_LIM   = 4'(MAX_OUTSTANDING);

    logic [3:0]            stall_cnt;
    logic [3:0]            outstanding;
    logic                  gnt;
    logic                  accept;
    logic                  in_range;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [WORD_W-1:0]     mem [DEPTH];
    mem_resp_t             resp_head;
    mem_resp_t             resp_tail;

    // Unsigned offset plus a lower-bound test keeps the range check free of wrap-around.
    assign offset   = bus.data_addr_i - BASE_ADDR;
    assign in_range = (bus.data_addr_i >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign word_idx = offset[ADDR_WIDTH+1:2];

    assign gnt    = bus.data_req_i && !rst_i && (stall_cnt == STALL_LIM) && (outstanding < OUT_LIM);
    assign accept = bus.data_req_i && gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!bus.data_req_i || accept) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_LIM) begin
            stall_cnt <= stall_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({accept, resp_tail.valid})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Backdoor assignment comes last so it overrides a same-cycle bus write.
    always_ff @(posedge clk_i) begin
        if (accept && bus.data_we_i && in_range) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (bus.data_be_i[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.data_wdata_i[8*i +: 8];
                end
            end
        end
        if (bd_we_i) begin
            mem[bd_addr_i] <= bd_wdata_i;
        end
    end

    always_comb begin
        resp_head       = '0;
        resp_head.valid = accept;
        if (accept) begin
            resp_head.err = !in_range;
            if (in_range && !bus.data_we_i) begin
                resp_head.rdata = mem[word_idx];
            end
        end
    end

    riscv_mem_resp_pipe #(
        .STAGES (RESP_LATENCY)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .head  (resp_head),
        .tail  (resp_tail)
    );

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = resp_tail.valid;
    assign bus.data_rdata_o  = resp_tail.rdata;
    assign bus.data_err_o    = resp_tail.err;

endmodule
